// File: rtl/shuffler_pipe.sv
// Two-stage brick shuffler: output brick j = input brick sel[j], valid/ready on both sides.
// Define SHUFFLER_ZERO_FILL_EN to zero out-of-range selects (default: substitute input brick 0).
module shuffler_pipe #(
  parameter int unsigned BL         = 256,
  parameter int unsigned IN_BRICKS  = 16,
  parameter int unsigned OUT_BRICKS = 16,
  parameter int unsigned SEL_BITS   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [IN_BRICKS*BL-1:0]        i_data,
  input  logic                           i_sel_we,
  input  logic [OUT_BRICKS*SEL_BITS-1:0] i_sel,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [OUT_BRICKS*BL-1:0]       o_data
);

  typedef logic [SEL_BITS-1:0]                  sel_t;
  typedef logic [OUT_BRICKS-1:0][SEL_BITS-1:0]  sel_vec_t;
  typedef logic [IN_BRICKS-1:0][BL-1:0]         in_vec_t;
  typedef logic [OUT_BRICKS-1:0][BL-1:0]        out_vec_t;

  function automatic sel_vec_t identity_sel();
    sel_vec_t r;
    for (int unsigned j = 0; j < OUT_BRICKS; j++) begin
      r[j] = sel_t'(j % IN_BRICKS);
    end
    return r;
  endfunction

  localparam sel_vec_t SEL_RST = identity_sel();

  logic     rdy_en_q;
  sel_vec_t sel_q, sel_d;
  logic     s1_valid_q, s1_valid_d;
  in_vec_t  s1_data_q;
  sel_vec_t s1_sel_q;
  logic     s2_valid_q, s2_valid_d;
  out_vec_t s2_data_q, mux_d;
  logic     accept, adv;

  // rdy_en_q holds o_ready low until the first edge after reset release
  assign o_ready = rdy_en_q & (~s1_valid_q | ~s2_valid_q | i_ready);
  assign accept  = i_valid & o_ready;
  assign adv     = s1_valid_q & (~s2_valid_q | i_ready);
  assign o_valid = s2_valid_q;
  assign o_data  = s2_data_q;

  always_comb begin
    sel_d      = i_sel_we ? sel_vec_t'(i_sel) : sel_q;
    s1_valid_d = accept | (s1_valid_q & ~adv);
    s2_valid_d = adv | (s2_valid_q & ~i_ready);
  end

  always_comb begin
    mux_d = '0;
    for (int unsigned j = 0; j < OUT_BRICKS; j++) begin
`ifdef SHUFFLER_ZERO_FILL_EN
      mux_d[j] = '0;
`else
      mux_d[j] = s1_data_q[0];
`endif
      for (int unsigned k = 0; k < IN_BRICKS; k++) begin
        if (32'(s1_sel_q[j]) == k) mux_d[j] = s1_data_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      sel_q      <= SEL_RST;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sel_q   <= SEL_RST;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      sel_q      <= sel_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_data_q <= i_data;
        s1_sel_q  <= sel_d;
      end
      if (adv) s2_data_q <= mux_d;
    end
  end

endmodule

// File: tb/tb_shuffler_pipe.sv
// Bench for shuffler_pipe: table vectors, directed handshake/reset sequences, random traffic vs a queue model.
module tb_shuffler_pipe;
  localparam int unsigned BL = 256, NI = 16, NO = 16, SB = 4;
  typedef logic [NI*BL-1:0] din_t;
  typedef logic [NO*BL-1:0] dout_t;
  typedef logic [NO*SB-1:0] sel_t;
  typedef struct { dout_t d; int unsigned due; } exp_t;
  typedef struct { logic we; logic [63:0] sel; logic [63:0] src; } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 1'b0, i_sel_we = 1'b0, i_ready = 1'b1;
  din_t i_data = '0;
  sel_t i_sel = '0;
  logic o_ready, o_valid;
  dout_t o_data;

  logic        n_i_valid = 1'b0, n_i_sel_we = 1'b0, n_i_ready = 1'b1;
  logic [95:0] n_i_data = '0;
  logic [15:0] n_i_sel = '0;
  logic        n_o_ready, n_o_valid;
  logic [31:0] n_o_data;

  always #5 clk = ~clk;

  shuffler_pipe #(.BL(256), .IN_BRICKS(16), .OUT_BRICKS(16), .SEL_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_sel_we(i_sel_we), .i_sel(i_sel), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data));

  shuffler_pipe #(.BL(8), .IN_BRICKS(12), .OUT_BRICKS(4), .SEL_BITS(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .i_valid(n_i_valid), .o_ready(n_o_ready), .i_data(n_i_data),
    .i_sel_we(n_i_sel_we), .i_sel(n_i_sel), .o_valid(n_o_valid), .i_ready(n_i_ready), .o_data(n_o_data));

  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0, nout = 0, last_out = 0;
  exp_t q[$];
  sel_t msel;
  bit rdy_ok = 1'b0;

  function automatic sel_t ident();
    sel_t r;
    for (int unsigned j = 0; j < NO; j++) r[j*SB +: SB] = SB'(j % NI);
    return r;
  endfunction

  function automatic dout_t model(input din_t d, input sel_t s);
    dout_t r;
    int unsigned idx;
    for (int unsigned j = 0; j < NO; j++) begin
      idx = 32'(s[j*SB +: SB]);
      if (idx < NI) r[j*BL +: BL] = d[idx*BL +: BL];
`ifdef SHUFFLER_ZERO_FILL_EN
      else r[j*BL +: BL] = '0;
`else
      else r[j*BL +: BL] = d[BL-1:0];
`endif
    end
    return r;
  endfunction

  function automatic din_t rand_din();
    din_t r;
    for (int unsigned w = 0; w < NI*BL/32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic din_t kdin();
    din_t r;
    for (int unsigned k = 0; k < NI; k++) r[k*BL +: BL] = BL'(k);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic chk_data(input string nm, input dout_t got, input dout_t want);
    int unsigned fj;
    total++;
    if (got !== want) begin
      bad++;
      fj = 0;
      for (int unsigned j = 0; j < NO; j++)
        if (got[j*BL +: BL] !== want[j*BL +: BL]) begin fj = j; break; end
      $display("FAIL %s: brick %0d got %h want %h (cycle %0d)", nm, fj,
               got[fj*BL +: BL], want[fj*BL +: BL], cyc);
    end
  endtask

  // One clock cycle: drive on negedge, check outputs, and advance the model for the coming posedge
  task automatic step(input logic v, input din_t d, input logic we, input sel_t s,
                      input logic rdy, output logic acc);
    bit exp_rdy, exp_vld;
    exp_t e;
    @(negedge clk);
    cyc++;
    i_valid = v; i_data = d; i_sel_we = we; i_sel = s; i_ready = rdy;
    #1;
    exp_rdy = rdy_ok && !(q.size() == 2 && !rdy);
    exp_vld = q.size() > 0 && cyc >= q[0].due;
    chk("o_ready", 64'(o_ready), 64'(exp_rdy));
    chk("o_valid", 64'(o_valid), 64'(exp_vld));
    if (exp_vld) chk_data("o_data", o_data, q[0].d);
    acc = v && exp_rdy;
    if (exp_vld && rdy) begin
      void'(q.pop_front());
      nout++;
      last_out = cyc;
    end
    if (acc) begin
      e.d = model(d, we ? s : msel);
      e.due = cyc + 2;
      q.push_back(e);
    end
    if (we) msel = s;
    rdy_ok = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    logic a;
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b1, a);
  endtask

  task automatic drain(input string nm);
    for (int unsigned i = 0; i < 20 && q.size() != 0; i++) idle(1);
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  vec_t tbl[7];
  dout_t expd;
  logic acc;
  int unsigned sent, n0, fa, nacc;
  bit seen_stall;
  logic [95:0] nd;
  logic [31:0] nexp;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 64'h0,                   64'hFEDC_BA98_7654_3210};
    tbl[1] = '{1'b1, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555};
    tbl[2] = '{1'b0, 64'h0,                   64'h5555_5555_5555_5555};
    tbl[3] = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    tbl[4] = '{1'b1, 64'h0000_0000_0000_000F, 64'h0000_0000_0000_000F};
    tbl[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_000F};
    tbl[6] = '{1'b1, 64'h3333_2222_1111_0000, 64'h3333_2222_1111_0000};
    msel = ident();

    // power-on reset
    repeat (3) @(negedge clk);
    #1;
    chk("reset o_valid", 64'(o_valid), 64'd0);
    chk("reset o_ready", 64'(o_ready), 64'd0);
    chk_data("reset o_data", o_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release o_ready", 64'(o_ready), 64'd0);
    rdy_ok = 1'b1;

    // table: single beats of brick k = k, expected source brick per output
    for (int unsigned i = 0; i < 7; i++) begin
      step(1'b1, kdin(), tbl[i].we, tbl[i].sel, 1'b1, acc);
      step(1'b0, '0, 1'b0, '0, 1'b1, acc);
      chk($sformatf("tbl%0d early valid", i), 64'(o_valid), 64'd0);
      step(1'b0, '0, 1'b0, '0, 1'b1, acc);
      for (int unsigned j = 0; j < NO; j++) expd[j*BL +: BL] = BL'(tbl[i].src[j*4 +: 4]);
      chk($sformatf("tbl%0d valid", i), 64'(o_valid), 64'd1);
      chk_data($sformatf("tbl%0d data", i), o_data, expd);
    end
    idle(2);

    // 10 back-to-back beats, downstream stalled in cycles 3..8
    sent = 0; n0 = nout; seen_stall = 1'b0;
    for (int unsigned t = 0; t < 60 && !(sent == 10 && q.size() == 0); t++) begin
      step(sent < 10, rand_din(), 1'b0, '0, !(t >= 3 && t <= 8), acc);
      if (acc) sent++;
      if (o_ready === 1'b0) seen_stall = 1'b1;
    end
    chk("bp beats out", 64'(nout - n0), 64'd10);
    chk("bp stall seen", 64'(seen_stall), 64'd1);

    // random traffic with select rewrites and backpressure
    for (int unsigned t = 0; t < 400; t++) begin
      step(($urandom % 4) != 0, rand_din(), ($urandom % 8) == 0,
           {$urandom(), $urandom()}, ($urandom % 3) != 0, acc);
    end
    drain("rand drain");

    // reset with two beats in flight after a select rewrite
    step(1'b1, rand_din(), 1'b1, {16{4'h7}}, 1'b1, acc);
    step(1'b1, rand_din(), 1'b0, '0, 1'b1, acc);
    @(negedge clk);
    rst_n = 1'b0; i_valid = 1'b0;
    #1;
    chk("midrst o_valid", 64'(o_valid), 64'd0);
    chk("midrst o_ready", 64'(o_ready), 64'd0);
    chk_data("midrst o_data", o_data, '0);
    q.delete();
    msel = ident();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst release o_ready", 64'(o_ready), 64'd0);
    rdy_ok = 1'b1;
    idle(3);
    step(1'b1, kdin(), 1'b0, '0, 1'b1, acc);
    idle(2);
    for (int unsigned j = 0; j < NO; j++) expd[j*BL +: BL] = BL'(j);
    chk("post-rst valid", 64'(o_valid), 64'd1);
    chk_data("post-rst identity", o_data, expd);
    idle(3);

    // 100 beats at full rate
    n0 = nout; fa = 0; nacc = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      step(1'b1, rand_din(), 1'b0, '0, 1'b1, acc);
      if (acc) begin
        if (nacc == 0) fa = cyc;
        nacc++;
      end
    end
    drain("b2b drain");
    chk("b2b accepted", 64'(nacc), 64'd100);
    chk("b2b outputs", 64'(nout - n0), 64'd100);
    chk("b2b span", 64'(last_out - fa), 64'd101);

    // narrow instance: 12 inputs, output 0 selects 13
    for (int unsigned k = 0; k < 12; k++) nd[k*8 +: 8] = 8'hA0 + 8'(k);
    @(negedge clk);
    n_i_valid = 1'b1; n_i_sel_we = 1'b1; n_i_sel = 16'hB37D; n_i_data = nd; n_i_ready = 1'b1;
    #1;
    chk("n o_ready", 64'(n_o_ready), 64'd1);
    @(negedge clk);
    n_i_valid = 1'b0; n_i_sel_we = 1'b0; n_i_sel = '0;
    #1;
    chk("n early valid", 64'(n_o_valid), 64'd0);
    @(negedge clk);
    #1;
`ifdef SHUFFLER_ZERO_FILL_EN
    nexp = {8'hAB, 8'hA3, 8'hA7, 8'h00};
`else
    nexp = {8'hAB, 8'hA3, 8'hA7, 8'hA0};
`endif
    chk("n valid", 64'(n_o_valid), 64'd1);
    chk("n oor data", 64'(n_o_data), 64'(nexp));
    nd[7:0] = 8'h5A;
    @(negedge clk);
    n_i_valid = 1'b1; n_i_data = nd;
    @(negedge clk);
    n_i_valid = 1'b0;
    @(negedge clk);
    #1;
`ifdef SHUFFLER_ZERO_FILL_EN
    nexp = {8'hAB, 8'hA3, 8'hA7, 8'h00};
`else
    nexp = {8'hAB, 8'hA3, 8'hA7, 8'h5A};
`endif
    chk("n persist valid", 64'(n_o_valid), 64'd1);
    chk("n persist data", 64'(n_o_data), 64'(nexp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
